// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the audio sample path between the Pi receiver and
// the I2S shifter: default sample width, default FIFO depth and the state
// encoding of the refill-request machine.
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FIFO_DEPTH = 8;

  // REQ is the reset state because an empty FIFO always wants samples.
  typedef enum logic {
    REFILL_IDLE = 1'b0,
    REFILL_REQ  = 1'b1
  } refill_state_t;

endpackage

// File: rtl/sample_fifo_if.sv
// sample_fifo_if
// Bundles the write side (Pi receiver), the read side (I2S shifter) and the
// status outputs of sample_fifo.
//   master : drives wr_en, wr_data, rd_en; observes the FIFO outputs
//   slave  : the FIFO itself
// Signals:
//   wr_en/wr_data  one-cycle write strobe and sample
//   rd_en          one-cycle read strobe, once per channel slot
//   rd_data        sample presented to the shifter, rd_valid pulses on update
//   full/empty     level == DEPTH / level == 0
//   level          current occupancy
//   refill_req     hysteretic request for more samples
//   overrun        pulse: a write was dropped
//   underrun       pulse: a read hit an empty FIFO
interface sample_fifo_if import audio_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = FIFO_DEPTH
);

  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic               rd_en;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               full;
  logic               empty;
  logic [LEVEL_W-1:0] level;
  logic               refill_req;
  logic               overrun;
  logic               underrun;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, level, refill_req, overrun, underrun
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, level, refill_req, overrun, underrun
  );

endinterface

// File: rtl/sample_fifo_mem.sv
// sample_fifo_mem
// DEPTH x DATA_W register array, one synchronous write port and one
// synchronous read port. No reset: contents are only meaningful where the
// owning FIFO's pointers say they are.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr    read port, rd_data registered, holds when rd_en=0
module sample_fifo_mem import audio_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // A same-address write and read returns the old entry, which is what the
  // full-FIFO simultaneous read/write needs.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_fifo.sv
// sample_fifo
// Sample buffer between the Pi receiver and the I2S shifter. Holds the
// pointers, the registered occupancy level, overrun/underrun detection and
// the hysteretic refill-request machine; storage lives in sample_fifo_mem.
// Ports:
//   clk   sole clock
//   rst   synchronous active-high reset
//   bus   sample_fifo_if slave: write/read strobes and all status outputs
module sample_fifo import audio_pkg::*; #(
  parameter int DATA_W  = SAMPLE_W,
  parameter int DEPTH   = FIFO_DEPTH,
  parameter int LOW_WM  = 2,
  parameter int HIGH_WM = 6
) (
  input  logic         clk,
  input  logic         rst,
  sample_fifo_if.slave bus
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;

  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] level_q, level_nxt;
  logic               full, empty;
  logic               wr_acc, rd_acc;
  logic               rd_zero;
  logic               rd_valid_q, overrun_q, underrun_q;
  logic [DATA_W-1:0]  mem_rd_data;
  refill_state_t      state_q, state_nxt;

  assign full  = (level_q == LEVEL_W'(DEPTH));
  assign empty = (level_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write paired with a read. Reads on an empty FIFO never see the write of
  // the same cycle (no fall-through).
  assign wr_acc = bus.wr_en && (!full || bus.rd_en) && !rst;
  assign rd_acc = bus.rd_en && !empty && !rst;

  always_comb begin
    level_nxt = level_q;
    if (wr_acc && !rd_acc)      level_nxt = level_q + LEVEL_W'(1);
    else if (!wr_acc && rd_acc) level_nxt = level_q - LEVEL_W'(1);
  end

  // rd_zero masks the memory read register, giving silence after reset and
  // after an underrun without needing a reset on the storage itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      rd_zero    <= 1'b1;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      level_q    <= level_nxt;
      rd_valid_q <= bus.rd_en;
      overrun_q  <= bus.wr_en && full && !bus.rd_en;
      underrun_q <= bus.rd_en && empty;
      if (bus.rd_en) rd_zero <= empty;
    end
  end

  // Refill request state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= REFILL_REQ;
    else     state_q <= state_nxt;
  end

  // Hysteresis on the level the FIFO is about to have, so the request
  // changes on the same edge the level crosses a watermark.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      REFILL_IDLE: if (level_nxt <= LEVEL_W'(LOW_WM))  state_nxt = REFILL_REQ;
      REFILL_REQ:  if (level_nxt >= LEVEL_W'(HIGH_WM)) state_nxt = REFILL_IDLE;
      default:     state_nxt = REFILL_REQ;
    endcase
  end

  sample_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  assign bus.rd_data    = rd_zero ? '0 : mem_rd_data;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = level_q;
  assign bus.refill_req = (state_q == REFILL_REQ);
  assign bus.overrun    = overrun_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo
// Self-checking bench for sample_fifo: a table of hand-computed vectors, a
// few hand-written corner-case sequences and a randomized run, all compared
// against a queue-based reference model of the FIFO behaviour.
module tb_sample_fifo;
  import audio_pkg::*;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;
  localparam int LOW_WM  = 2;
  localparam int HIGH_WM = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sample_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sample_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LOW_WM  (LOW_WM),
    .HIGH_WM (HIGH_WM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_rd_data = '0;
  bit                m_rv, m_ov, m_un;
  bit                m_refill = 1'b1;

  typedef struct {
    bit          rst;
    bit          we;
    logic [15:0] wd;
    bit          re;
    int          lvl;
    logic [15:0] rd;
    bit          rv;
    bit          ov;
    bit          un;
    bit          rf;
  } vec_t;

  vec_t tbl[12];

  // Drive one cycle of inputs at the falling edge, sample just after the
  // following rising edge.
  task automatic applyStimulus(input bit r, input bit we, input logic [15:0] wd, input bit re);
    @(negedge clk);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
    vectors++;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input int lvl, input logic [15:0] rd,
                             input bit rv, input bit ov, input bit un, input bit rf);
    checkField({tag, ".level"},      32'(bus.level),      32'(lvl));
    checkField({tag, ".full"},       32'(bus.full),       32'(lvl == DEPTH));
    checkField({tag, ".empty"},      32'(bus.empty),      32'(lvl == 0));
    checkField({tag, ".rd_data"},    32'(bus.rd_data),    32'(rd));
    checkField({tag, ".rd_valid"},   32'(bus.rd_valid),   32'(rv));
    checkField({tag, ".overrun"},    32'(bus.overrun),    32'(ov));
    checkField({tag, ".underrun"},   32'(bus.underrun),   32'(un));
    checkField({tag, ".refill_req"}, 32'(bus.refill_req), 32'(rf));
  endtask

  // Behavioural FIFO: a queue, with read taken before write so a full FIFO
  // frees a slot and an empty FIFO never forwards the incoming sample.
  task automatic modelStep(input bit r, input bit we, input logic [15:0] wd, input bit re);
    int sz;
    bit was_full, was_empty;
    if (r) begin
      mq.delete();
      m_rd_data = '0;
      m_rv = 0; m_ov = 0; m_un = 0;
      m_refill = 1;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_rv = re;
      m_un = re && was_empty;
      m_ov = we && was_full && !re;
      if (re) m_rd_data = was_empty ? 16'h0000 : mq.pop_front();
      if (we && (!was_full || re)) mq.push_back(wd);
      sz = mq.size();
      if (sz <= LOW_WM)       m_refill = 1;
      else if (sz >= HIGH_WM) m_refill = 0;
    end
  endtask

  task automatic step(input string tag, input bit r, input bit we, input logic [15:0] wd, input bit re);
    applyStimulus(r, we, wd, re);
    modelStep(r, we, wd, re);
    checkOutput(tag, mq.size(), m_rd_data, m_rv, m_ov, m_un, m_refill);
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    //            rst we  wd        re  lvl rd        rv ov un rf
    tbl[0]  = '{1, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 16'h1111, 0,  1, 16'h0000, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 16'h2222, 0,  2, 16'h0000, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 16'h3333, 0,  3, 16'h0000, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 16'h0000, 1,  2, 16'h1111, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 16'h0000, 1,  1, 16'h2222, 1, 0, 0, 1};
    tbl[6]  = '{0, 0, 16'h0000, 1,  0, 16'h3333, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 16'h0000, 0,  0, 16'h3333, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 16'h0000, 1,  0, 16'h0000, 1, 0, 1, 1};
    tbl[9]  = '{0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 16'h5555, 1,  1, 16'h0000, 1, 0, 1, 1};
    tbl[11] = '{0, 0, 16'h0000, 1,  0, 16'h5555, 1, 0, 0, 1};

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].re);
      modelStep(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].re);
      checkOutput($sformatf("tbl%0d", i), tbl[i].lvl, tbl[i].rd,
                  tbl[i].rv, tbl[i].ov, tbl[i].un, tbl[i].rf);
    end

    $display("[TB] fill past full");
    step("fill_rst", 1, 0, 16'h0, 0);
    for (int i = 0; i < 8; i++) step($sformatf("fill%0d", i), 0, 1, 16'h0100 + 16'(i), 0);
    checkField("full_after_8", 32'(bus.full), 32'd1);
    step("fill_drop", 0, 1, 16'h0BAD, 0);
    checkField("overrun_on_9th", 32'(bus.overrun), 32'd1);
    checkField("level_after_9", 32'(bus.level), 32'd8);
    step("fill_idle", 0, 0, 16'h0, 0);
    checkField("overrun_one_pulse", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("drain%0d", i), 0, 0, 16'h0, 1);
      checkField($sformatf("drain_data%0d", i), 32'(bus.rd_data), 32'h0100 + 32'(i));
    end

    $display("[TB] simultaneous read/write at full and empty");
    for (int i = 0; i < 8; i++) step($sformatf("refull%0d", i), 0, 1, 16'h0200 + 16'(i), 0);
    step("full_rw", 0, 1, 16'hAAAA, 1);
    checkField("full_rw_overrun", 32'(bus.overrun), 32'd0);
    checkField("full_rw_level", 32'(bus.level), 32'd8);
    for (int i = 0; i < 8; i++) step($sformatf("full_rw_drain%0d", i), 0, 0, 16'h0, 1);
    checkField("aaaa_read_8th", 32'(bus.rd_data), 32'hAAAA);
    step("empty_rw", 0, 1, 16'h5A5A, 1);
    checkField("empty_rw_underrun", 32'(bus.underrun), 32'd1);
    checkField("empty_rw_level", 32'(bus.level), 32'd1);
    checkField("empty_rw_data", 32'(bus.rd_data), 32'h0000);

    $display("[TB] refill hysteresis");
    step("wm_rst", 1, 0, 16'h0, 0);
    checkField("refill_after_reset", 32'(bus.refill_req), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("wm_wr%0d", i), 0, 1, 16'h0300 + 16'(i), 0);
      checkField($sformatf("refill_at_level%0d", i), 32'(bus.refill_req), (i < 6) ? 32'd1 : 32'd0);
    end
    for (int i = 5; i >= 2; i--) begin
      step($sformatf("wm_rd%0d", i), 0, 0, 16'h0, 1);
      checkField($sformatf("refill_down_level%0d", i), 32'(bus.refill_req), (i > 2) ? 32'd0 : 32'd1);
    end

    $display("[TB] reset mid-stream");
    step("mid_rst0", 1, 0, 16'h0, 0);
    for (int i = 0; i < 6; i++) step($sformatf("mid_wr%0d", i), 0, 1, 16'h0400 + 16'(i), 0);
    step("mid_rd", 0, 0, 16'h0, 1);
    step("mid_rst", 1, 1, 16'hDEAD, 1);
    checkField("mid_rst_level", 32'(bus.level), 32'd0);
    checkField("mid_rst_empty", 32'(bus.empty), 32'd1);
    checkField("mid_rst_refill", 32'(bus.refill_req), 32'd1);
    checkField("mid_rst_data", 32'(bus.rd_data), 32'h0000);
    step("post_rst_rd", 0, 0, 16'h0, 1);
    checkField("post_rst_underrun", 32'(bus.underrun), 32'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      bit r, we, re;
      int wbias;
      wbias = (i % 200 < 100) ? 70 : 30;
      r  = ($urandom_range(0, 79) == 0);
      we = ($urandom_range(0, 99) < wbias);
      re = ($urandom_range(0, 99) < (100 - wbias));
      step($sformatf("rnd%0d", i), r, we, 16'($urandom), re);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of sample entries; power of two, at least 4.
REQ-003 The block SHALL have parameter LOW_WM, default 2, meaning the level at or below which refill is requested.
REQ-004 The block SHALL have parameter HIGH_WM, default 6, meaning the level at or above which refill is withdrawn; LOW_WM < HIGH_WM <= DEPTH.
REQ-005 The block SHALL have one clock and a synchronous active-high reset: clk is the single clock (all logic on posedge clk) and rst is the synchronous active-high reset.
REQ-006 clk  in  1  sole clock, the divided system clock shared with the Pi receiver.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  one-cycle strobe from the Pi receiver: wr_data holds a complete sample.
REQ-009 wr_data  in  DATA_W  sample from the Pi receiver.
REQ-010 rd_en  in  1  one-cycle strobe from the I2S shifter side, once per channel slot.
REQ-011 rd_data  out  DATA_W  sample presented to the I2S shifter.
REQ-012 rd_valid  out  1  one-cycle pulse: rd_data updated.
REQ-013 full  out  1  level == DEPTH.
REQ-014 empty  out  1  level == 0.
REQ-015 level  out  clog2(DEPTH)+1  current occupancy.
REQ-016 refill_req  out  1  hysteretic request to the Pi for more samples; drives the interrupt path.
REQ-017 overrun  out  1  one-cycle pulse: a write was dropped.
REQ-018 underrun  out  1  one-cycle pulse: a read hit an empty FIFO.

Function
REQ-019 A write SHALL be accepted when wr_en=1 and (full=0 or rd_en=1 in the same cycle); the sample is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-020 When wr_en=1, full=1 and rd_en=0, the write SHALL be dropped, nothing SHALL change, and overrun SHALL pulse the next cycle.
REQ-021 When rd_en=1 and empty=0, the block SHALL load the entry at rd_ptr into rd_data on the next edge, increment rd_ptr modulo DEPTH, and pulse rd_valid for one cycle; read latency is 1 clk.
REQ-022 When rd_en=1 and empty=1, rd_data SHALL load all-zero (silence), rd_valid and underrun SHALL pulse, and the pointers SHALL remain unchanged.
REQ-023 A simultaneous write and read on an empty FIFO SHALL have no fall-through: the write is stored, the read underruns with zero output, and level becomes 1.
REQ-024 A simultaneous write and read on a full FIFO SHALL accept both, leave level at DEPTH, and produce no overrun.
REQ-025 Otherwise, a simultaneous accepted write and read SHALL leave level unchanged.
REQ-026 level SHALL be registered and updated on the same edge as the pointers; full and empty SHALL be decoded from level.
REQ-027 rd_data SHALL hold its last value between reads.
REQ-028 refill_req SHALL be a 2-state machine, IDLE and REQ: IDLE->REQ when the next level <= LOW_WM; REQ->IDLE when the next level >= HIGH_WM; it holds otherwise.
REQ-029 overrun and underrun SHALL never be high for more than one cycle per event.

Reset
REQ-030 While rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overrun=0, underrun=0, and the state machine is REQ (refill_req=1, because the FIFO is empty).
REQ-031 Reset mid-operation SHALL discard all stored samples; memory contents need not be cleared.
REQ-032 wr_en and rd_en asserted during rst SHALL be ignored.

Structure
REQ-033 Shared package audio_pkg SHALL hold SAMPLE_W=16, FIFO_DEPTH=8, and the refill-state encoding (REFILL_IDLE, REFILL_REQ).
REQ-034 Storage SHALL be sub-module sample_fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one synchronous read port, no reset.
REQ-035 Pointer, level and watermark logic SHALL reside in sample_fifo.

Verification
REQ-036 After reset, write 0x1111, 0x2222, 0x3333, then rd_en x3 -> rd_data 0x1111, 0x2222, 0x3333, each one cycle after rd_en with a rd_valid pulse; level ends at 0.
REQ-037 Write 9 samples with no reads -> full after the 8th, overrun pulses once on the 9th, level=8; reading 8 returns the first 8 in order.
REQ-038 rd_en on an empty FIFO -> rd_data=0x0000, rd_valid=1, underrun=1 for one cycle; level stays 0.
REQ-039 With level=8, assert wr_en(0xAAAA) and rd_en together -> no overrun, level=8, and 0xAAAA is read 8th afterwards; with level=0, the same -> underrun, level=1.
REQ-040 refill_req: starts 1; writes to level 6 -> 0 on the edge level reaches 6; reads to level 3 -> stays 0; level 2 -> 1.
REQ-041 Assert rst with level=5 mid-stream -> level=0, empty=1, refill_req=1, rd_data=0; the next read underruns.
